// File: rtl/st_delimiter_extractor.sv
// Strips SOP/EOP delimiter words out of an Avalon-ST stream and forwards only data words.
// Each delimiter is queued with its type and the frame's data-word count for software to read.
module st_delimiter_extractor #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 delim_read,
  output logic                 delim_waitrequest,
  output logic [WIDTH-1:0]     delim_readdata,
  output logic                 delim_is_eop,
  output logic [CNT_WIDTH-1:0] delim_count,
  output logic                 proto_err,
  input  logic                 err_clear,
  output logic                 dbg_inside
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic {
    OUTSIDE = 1'b0,
    INSIDE  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 err_set;

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;

  logic [WIDTH-1:0]     mem_data_q [DEPTH];
  logic                 mem_eop_q  [DEPTH];
  logic [CNT_WIDTH-1:0] mem_cnt_q  [DEPTH];
  logic [AW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [AW:0]          occ_q;

  logic                 fifo_full, fifo_empty;
  logic                 accept, acc_sop, acc_eop, acc_data;
  logic                 push, pop;
  logic [CNT_WIDTH-1:0] push_cnt;

  // Handshakes: a transfer happens on any edge where valid and ready are both 1;
  // ready never looks at valid, and a delim_read is honoured only while waitrequest is 0.
  assign fifo_full  = (occ_q == FULL_OCC);
  assign fifo_empty = (occ_q == '0);
  assign in_ready   = reset_n & (~out_valid_q | out_ready) & ~fifo_full;
  assign accept     = in_valid & in_ready;
  assign acc_eop    = accept & in_eop;
  assign acc_sop    = accept & in_sop & ~in_eop;
  assign acc_data   = accept & ~in_sop & ~in_eop;
  assign push       = acc_sop | acc_eop;

  assign delim_waitrequest = fifo_empty | ~reset_n;
  assign pop               = delim_read & ~delim_waitrequest;

  assign delim_readdata = fifo_empty ? '0   : mem_data_q[rd_ptr_q];
  assign delim_is_eop   = fifo_empty ? 1'b0 : mem_eop_q[rd_ptr_q];
  assign delim_count    = fifo_empty ? '0   : mem_cnt_q[rd_ptr_q];

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign proto_err  = err_q;
  assign dbg_inside = (state_q == INSIDE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= OUTSIDE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUTSIDE: if (acc_sop) state_d = INSIDE;
      INSIDE:  if (acc_eop) state_d = OUTSIDE;
      default: state_d = OUTSIDE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    push_cnt = '0;
    err_set  = 1'b0;
    case (state_q)
      OUTSIDE: begin
        if (acc_sop) cnt_d = '0;
        if (acc_eop) err_set = 1'b1;
      end
      INSIDE: begin
        if (acc_data && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (acc_sop) begin
          cnt_d   = '0;
          err_set = 1'b1;
        end
        if (acc_eop) push_cnt = cnt_q;
      end
      default: ;
    endcase
    // A word flagged both SOP and EOP is handled as EOP but is always an error.
    if (accept && in_sop && in_eop) err_set = 1'b1;
    err_d = err_set ? 1'b1 : (err_clear ? 1'b0 : err_q);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_ready) out_valid_d = 1'b0;
    if (acc_data) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= in_data;
      mem_eop_q[wr_ptr_q]  <= in_eop;
      mem_cnt_q[wr_ptr_q]  <= push_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_st_delimiter_extractor.sv
// Bench for st_delimiter_extractor: directed scenarios then random traffic, all checked
// against a queue-based reference model; a CNT_WIDTH=2 instance shares the stimulus.
module tb_st_delimiter_extractor;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0, delim_read = 1'b0, err_clear = 1'b0;

  logic          in_ready, out_valid, delim_waitrequest, delim_is_eop, proto_err, dbg_inside;
  logic [W-1:0]  out_data, delim_readdata;
  logic [CW-1:0] delim_count;

  logic          s_in_ready, s_out_valid, s_waitreq, s_is_eop, s_err, s_inside;
  logic [W-1:0]  s_out_data, s_readdata;
  logic [1:0]    s_count;

  always #5 clock = ~clock;

  st_delimiter_extractor #(.WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(CW)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .delim_read(delim_read),
    .delim_waitrequest(delim_waitrequest), .delim_readdata(delim_readdata),
    .delim_is_eop(delim_is_eop), .delim_count(delim_count), .proto_err(proto_err),
    .err_clear(err_clear), .dbg_inside(dbg_inside)
  );

  st_delimiter_extractor #(.WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(2)) u_sat (
    .clock(clock), .reset_n(reset_n), .in_ready(s_in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .out_ready(out_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .delim_read(delim_read),
    .delim_waitrequest(s_waitreq), .delim_readdata(s_readdata),
    .delim_is_eop(s_is_eop), .delim_count(s_count), .proto_err(s_err),
    .err_clear(err_clear), .dbg_inside(s_inside)
  );

  typedef struct {
    logic [W-1:0] d;
    bit           e;
    int           c;
  } ent_t;

  logic [W-1:0] exp_q[$];
  ent_t         fq[$];
  bit           m_inside;
  int           m_cnt;
  bit           m_err;
  bit           last_acc;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  // Compare every output with the model, then advance one clock and update the model.
  task automatic tick();
    bit rdy, acc, set_err;
    #1;
    rdy = reset_n && (exp_q.size() == 0 || out_ready) && (fq.size() < DEPTH);
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
    check("waitrequest", delim_waitrequest, !reset_n || fq.size() == 0);
    if (fq.size() == 0) begin
      check("readdata_empty", delim_readdata, 0);
      check("is_eop_empty", delim_is_eop, 0);
      check("count_empty", delim_count, 0);
    end else if (reset_n) begin
      check("readdata", delim_readdata, fq[0].d);
      check("is_eop", delim_is_eop, fq[0].e);
      check("count", delim_count, sat(fq[0].c, 65535));
      check("count_sat", s_count, sat(fq[0].c, 3));
    end
    check("proto_err", proto_err, m_err);
    check("inside", dbg_inside, m_inside);
    acc = in_valid && rdy;
    last_acc = acc;
    @(posedge clock);
    if (!reset_n) begin
      exp_q.delete();
      fq.delete();
      m_inside = 0;
      m_cnt    = 0;
      m_err    = 0;
    end else begin
      set_err = 0;
      if (delim_read && fq.size() != 0) fq.delete(0);
      if (exp_q.size() != 0 && out_ready) exp_q.delete(0);
      if (acc) begin
        if (in_eop) begin
          fq.push_back('{in_data, 1'b1, m_inside ? m_cnt : 0});
          if (!m_inside || in_sop) set_err = 1;
          m_inside = 0;
        end else if (in_sop) begin
          if (m_inside) set_err = 1;
          fq.push_back('{in_data, 1'b0, 0});
          m_cnt    = 0;
          m_inside = 1;
        end else begin
          exp_q.push_back(in_data);
          if (m_inside) m_cnt++;
        end
      end
      if (set_err) m_err = 1;
      else if (err_clear) m_err = 0;
    end
    @(negedge clock);
  endtask

  task automatic send(input logic [W-1:0] d, input bit s, input bit e);
    int budget = 20;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    do begin
      tick();
      budget--;
    end while (!last_acc && budget > 0);
    if (!last_acc) check("send_timeout", 0, 1);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic drain();
    int budget = 2 * DEPTH + 2;
    delim_read = 1'b1;
    while (!delim_waitrequest && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("drain_timeout", 0, 1);
    delim_read = 1'b0;
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_waitreq", delim_waitrequest, 1);
    check("rst_readdata", delim_readdata, 0);
    check("rst_count", delim_count, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_inside", dbg_inside, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Frame and drain
    out_ready = 1'b1;
    send(8'hA5, 1, 0);
    send(8'h11, 0, 0);
    check("frm_d0", out_data, 8'h11);
    send(8'h22, 0, 0);
    check("frm_d1", out_data, 8'h22);
    send(8'h33, 0, 0);
    check("frm_d2", out_data, 8'h33);
    send(8'h5A, 0, 1);
    check("frm_head0", delim_readdata, 8'hA5);
    check("frm_head0_eop", delim_is_eop, 0);
    delim_read = 1'b1;
    tick();
    delim_read = 1'b0;
    check("frm_head1", delim_readdata, 8'h5A);
    check("frm_head1_eop", delim_is_eop, 1);
    check("frm_head1_cnt", delim_count, 3);
    drain();
    check("frm_empty", delim_waitrequest, 1);

    // Backpressure
    out_ready = 1'b0;
    send(8'h01, 0, 0);
    in_valid = 1'b1; in_data = 8'h02;
    repeat (3) tick();
    check("bp_ready_low", in_ready, 0);
    check("bp_hold", out_data, 8'h01);
    out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    check("bp_next", out_data, 8'h02);
    check("bp_valid", out_valid, 1);
    tick();

    // FIFO full
    send(8'h10, 1, 0);
    send(8'h20, 0, 1);
    send(8'h30, 1, 0);
    send(8'h40, 0, 1);
    in_valid = 1'b1; in_data = 8'h50; in_sop = 1'b1;
    tick();
    check("full_ready_low", in_ready, 0);
    check("full_not_taken", last_acc, 0);
    delim_read = 1'b1;
    tick();
    delim_read = 1'b0;
    check("full_reenable", in_ready, 1);
    tick();
    check("full_fifth_in", last_acc, 1);
    in_valid = 1'b0; in_sop = 1'b0;
    drain();
    clear_err();

    // Read and write together (state is INSIDE here, so this SOP flags an error)
    send(8'h61, 1, 0);
    in_valid = 1'b1; in_data = 8'h71; in_eop = 1'b1; delim_read = 1'b1;
    tick();
    in_valid = 1'b0; in_eop = 1'b0; delim_read = 1'b0;
    check("rw_head", delim_readdata, 8'h71);
    check("rw_head_eop", delim_is_eop, 1);
    check("rw_occ1", delim_waitrequest, 0);
    delim_read = 1'b1;
    tick();
    delim_read = 1'b0;
    check("rw_empty", delim_waitrequest, 1);
    clear_err();

    // Protocol errors
    check("pe_clear", proto_err, 0);
    send(8'h81, 0, 1);
    check("pe_eop_outside", proto_err, 1);
    check("pe_eop_cnt", delim_count, 0);
    clear_err();
    drain();
    send(8'h82, 1, 0);
    send(8'h83, 1, 0);
    check("pe_sop_inside", proto_err, 1);
    clear_err();
    drain();
    send(8'h84, 1, 1);
    check("pe_both", proto_err, 1);
    check("pe_both_eop", delim_is_eop, 1);
    clear_err();
    err_clear = 1'b1;
    send(8'h85, 0, 1);
    err_clear = 1'b0;
    check("pe_set_wins", proto_err, 1);
    clear_err();
    drain();

    // Mid-frame reset
    send(8'h91, 1, 0);
    send(8'h92, 0, 0);
    send(8'h93, 0, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mr_out_valid", out_valid, 0);
    check("mr_waitreq", delim_waitrequest, 1);
    check("mr_inside", dbg_inside, 0);
    tick();

    // Counter saturation on the CNT_WIDTH=2 instance
    send(8'hA0, 1, 0);
    for (int i = 0; i < 5; i++) send(8'(i + 1), 0, 0);
    send(8'hA1, 0, 1);
    delim_read = 1'b1;
    tick();
    delim_read = 1'b0;
    check("sat_cnt2", s_count, 3);
    check("sat_cnt16", delim_count, 5);
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_data    = 8'($urandom);
      r          = $urandom_range(0, 15);
      in_sop     = (r < 2) || (r == 4);
      in_eop     = (r == 2) || (r == 3) || (r == 4);
      out_ready  = ($urandom_range(0, 3) != 0);
      delim_read = ($urandom_range(0, 2) == 0);
      err_clear  = ($urandom_range(0, 15) == 0);
      reset_n    = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset_n = 1'b1; in_valid = 1'b0; delim_read = 1'b0; err_clear = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
